// File: rtl/simon_pkg.sv
// Shared types, constants and helpers for the Simon sequence engine.
package simon_pkg;

    typedef enum logic [3:0] {
        IDLE,
        CLEAR,
        ADD,
        PLAY_ON,
        PLAY_OFF,
        WAIT_IN,
        ECHO,
        PAUSE,
        OVER,
        WIN
    } state_t;

    localparam logic [15:0] LFSR_MASK    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    // Bits needed to index n items; never less than one bit.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/simon_lfsr.sv
// 16-bit Galois LFSR (right-shifting) that advances every clock and reloads SEED on reset.
module simon_lfsr
    import simon_pkg::*;
#(
    parameter logic [15:0] SEED = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] lfsr
);

    if (SEED == 16'h0000) begin : g_seed_check
        $error("simon_lfsr: SEED must be nonzero");
    end

    // NOTE: registers are written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr <= SEED;
        end else begin
            lfsr <= (lfsr >> 1) ^ (lfsr[0] ? LFSR_MASK : 16'h0000);
        end
    end

endmodule

// File: rtl/simon_seq_engine.sv
// Simon sequence engine: grows, plays back and checks a pseudo-random channel sequence.
// Defining SIMON_TIMEOUT_EN adds a player inactivity timeout in WAIT_IN.
module simon_seq_engine
    import simon_pkg::*;
#(
    parameter int          NUM_CH         = 4,
    parameter int          MAX_LEN        = 32,
    parameter int          TONE_CYCLES    = 25_000_000,
    parameter int          GAP_CYCLES     = 12_500_000,
    parameter int          TIMEOUT_CYCLES = 250_000_000,
    parameter logic [15:0] SEED           = DEFAULT_SEED,
    localparam int         CH_W           = width_of(NUM_CH),
    localparam int         LV_W           = $clog2(MAX_LEN + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [CH_W-1:0] btn_num,
    input  logic            btn_pulse,
    output logic            simon_turn,
    output logic [CH_W-1:0] cur_num,
    output logic            cur_active,
    output logic [LV_W-1:0] level,
    output logic            game_over,
    output logic            win
);

    localparam int IDX_W  = width_of(MAX_LEN);
    localparam int TG_MAX = (TONE_CYCLES > GAP_CYCLES) ? TONE_CYCLES : GAP_CYCLES;
`ifdef SIMON_TIMEOUT_EN
    localparam int TMR_MAX = (TIMEOUT_CYCLES > TG_MAX) ? TIMEOUT_CYCLES : TG_MAX;
`else
    localparam int TMR_MAX = TG_MAX;
`endif
    localparam int               TMR_W     = width_of(TMR_MAX);
    localparam logic [TMR_W-1:0] TONE_LAST = TMR_W'(TONE_CYCLES - 1);
    localparam logic [TMR_W-1:0] GAP_LAST  = TMR_W'(GAP_CYCLES - 1);
`ifdef SIMON_TIMEOUT_EN
    localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
`endif

    if (NUM_CH < 2 || NUM_CH > 16 || MAX_LEN < 1 || TONE_CYCLES < 1 ||
        GAP_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("simon_seq_engine: illegal parameter value");
    end

    state_t           state_q, state_d;
    logic [LV_W-1:0]  level_q, level_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [CH_W-1:0]  mem [MAX_LEN];
    logic [15:0]      lfsr;
    logic [CH_W-1:0]  new_ch;
    logic [CH_W-1:0]  exp_ch;
    logic [LV_W-1:0]  idx_inc;
    logic             btn_ok;

    simon_lfsr #(
        .SEED(SEED)
    ) u_lfsr (
        .clk  (clk),
        .reset(reset),
        .lfsr (lfsr)
    );

    assign new_ch  = CH_W'(lfsr % 16'(NUM_CH));
    assign exp_ch  = mem[idx_q];
    assign idx_inc = LV_W'(idx_q) + LV_W'(1);
    assign btn_ok  = (32'(btn_num) < NUM_CH) && (btn_num == exp_ch);
    assign level   = level_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            level_q <= '0;
            idx_q   <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            idx_q   <= idx_d;
            timer_q <= timer_d;
        end
    end

    // NOTE: the sequence store is deliberately not reset; only entries below level are read.
    always_ff @(posedge clk) begin
        if (!reset && state_q == ADD) begin
            mem[IDX_W'(level_q)] <= new_ch;
        end
    end

    // Every state change leaves timer_d at its zero default, so each phase counts from 0.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d = state_q;
        level_d = level_q;
        idx_d   = idx_q;
        timer_d = '0;
        if (start) begin
            state_d = CLEAR;
        end else begin
            unique case (state_q)
                IDLE: ;
                CLEAR: begin
                    level_d = '0;
                    idx_d   = '0;
                    state_d = ADD;
                end
                ADD: begin
                    level_d = level_q + LV_W'(1);
                    idx_d   = '0;
                    state_d = PLAY_ON;
                end
                PLAY_ON: begin
                    if (timer_q == TONE_LAST) state_d = PLAY_OFF;
                    else                      timer_d = timer_q + TMR_W'(1);
                end
                PLAY_OFF: begin
                    if (timer_q == GAP_LAST) begin
                        if (idx_inc == level_q) begin
                            idx_d   = '0;
                            state_d = WAIT_IN;
                        end else begin
                            idx_d   = idx_q + IDX_W'(1);
                            state_d = PLAY_ON;
                        end
                    end else begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end
                WAIT_IN: begin
                    if (btn_pulse) state_d = btn_ok ? ECHO : OVER;
`ifdef SIMON_TIMEOUT_EN
                    else if (timer_q == TIMEOUT_LAST) state_d = OVER;
                    else timer_d = timer_q + TMR_W'(1);
`endif
                end
                ECHO: begin
                    if (timer_q == TONE_LAST) begin
                        if (idx_inc < level_q) begin
                            idx_d   = idx_q + IDX_W'(1);
                            state_d = WAIT_IN;
                        end else if (level_q == LV_W'(MAX_LEN)) begin
                            state_d = WIN;
                        end else begin
                            state_d = PAUSE;
                        end
                    end else begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end
                PAUSE: begin
                    if (timer_q == GAP_LAST) state_d = ADD;
                    else                     timer_d = timer_q + TMR_W'(1);
                end
                OVER, WIN: ;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        simon_turn = 1'b0;
        cur_active = 1'b0;
        cur_num    = '0;
        game_over  = 1'b0;
        win        = 1'b0;
        case (state_q)
            ADD, PLAY_OFF, PAUSE: simon_turn = 1'b1;
            PLAY_ON: begin
                simon_turn = 1'b1;
                cur_active = 1'b1;
                cur_num    = exp_ch;
            end
            // The accepted press equals mem[idx], so the echo replays the stored channel.
            ECHO: begin
                cur_active = 1'b1;
                cur_num    = exp_ch;
            end
            OVER: begin
                game_over  = 1'b1;
                cur_active = 1'b1;
            end
            WIN: win = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_simon_seq_engine.sv
// Self-checking bench for simon_seq_engine: vector table, directed corner cases and random games.
`timescale 1ns/1ps
module tb_simon_seq_engine;

    localparam int          NUM_CH  = 4;
    localparam int          MAX_LEN = 3;
    localparam int          TONE    = 4;
    localparam int          GAP     = 2;
    localparam int          TOUT    = 10;
    localparam logic [15:0] SEED    = 16'hACE1;
    localparam int          NVEC    = 18;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       btn_pulse = 1'b0;
    logic [1:0] btn_num = 2'd0;
    logic       simon_turn, cur_active, game_over, win;
    logic [1:0] cur_num, level;

    logic       start5 = 1'b0;
    logic       pulse5 = 1'b0;
    logic [2:0] btn5 = 3'd0;
    logic       turn5, act5, over5, win5;
    logic [2:0] num5;
    logic [1:0] level5;

    int checks = 0;
    int errors = 0;
    int adv = 0;
    int seq[$];

    typedef struct {
        logic       start;
        logic       pulse;
        logic [1:0] num;
        logic       e_turn;
        logic       e_act;
        logic [1:0] e_num;
        logic       e_over;
        logic       e_win;
        logic       chk_lvl;
        logic [1:0] e_lvl;
    } vec_t;

    vec_t       vecs[NVEC];
    logic [1:0] ch_a, ch_b;

    simon_seq_engine #(
        .NUM_CH(NUM_CH), .MAX_LEN(MAX_LEN), .TONE_CYCLES(TONE), .GAP_CYCLES(GAP),
        .TIMEOUT_CYCLES(TOUT), .SEED(SEED)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .btn_num(btn_num), .btn_pulse(btn_pulse),
        .simon_turn(simon_turn), .cur_num(cur_num), .cur_active(cur_active), .level(level),
        .game_over(game_over), .win(win)
    );

    simon_seq_engine #(
        .NUM_CH(5), .MAX_LEN(MAX_LEN), .TONE_CYCLES(TONE), .GAP_CYCLES(GAP),
        .TIMEOUT_CYCLES(TOUT), .SEED(SEED)
    ) dut5 (
        .clk(clk), .reset(reset), .start(start5), .btn_num(btn5), .btn_pulse(pulse5),
        .simon_turn(turn5), .cur_num(num5), .cur_active(act5), .level(level5),
        .game_over(over5), .win(win5)
    );

    always #5 clk = ~clk;

    // Clock edges since the last reset edge: the LFSR has stepped this many times from SEED.
    always @(posedge clk) adv <= reset ? 0 : adv + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] lfsr_after(input int n);
        logic [15:0] v;
        v = SEED;
        for (int i = 0; i < n; i++) v = v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
        return v;
    endfunction

    function automatic logic [1:0] chan_now();
        return 2'(lfsr_after(adv) % NUM_CH);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Channel number is compared only while a channel is active.
    task automatic check_outs(input string name, input logic e_turn, input logic e_act,
                              input logic [1:0] e_num, input logic e_over, input logic e_win);
        check(name, {26'd0, simon_turn, cur_active, (cur_active ? cur_num : 2'd0), game_over, win},
              {26'd0, e_turn, e_act, e_num, e_over, e_win});
    endtask

    task automatic reset_dut();
        reset = 1'b1; start = 1'b0; btn_pulse = 1'b0; start5 = 1'b0; pulse5 = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic press(input logic [1:0] ch);
        btn_num = ch;
        btn_pulse = 1'b1;
        step();
        btn_pulse = 1'b0;
    endtask

    // Pulses start and follows CLEAR and the first ADD; ends on the first PLAY_ON cycle.
    task automatic start_game();
        start = 1'b1;
        step();
        start = 1'b0;
        check_outs("clear", 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        step();
        check_outs("add", 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
        check("add_level", 32'(level), 32'd0);
        seq.delete();
        seq.push_back(int'(chan_now()));
        step();
    endtask

    // Expects the whole stored sequence replayed; ends on the first WAIT_IN cycle.
    task automatic check_playback();
        for (int i = 0; i < seq.size(); i++) begin
            for (int t = 0; t < TONE; t++) begin
                check_outs("play_on", 1'b1, 1'b1, 2'(seq[i]), 1'b0, 1'b0);
                step();
            end
            for (int t = 0; t < GAP; t++) begin
                check_outs("play_off", 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
                step();
            end
        end
        check_outs("wait_in", 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        check("wait_level", 32'(level), 32'(seq.size()));
    endtask

    // Plays a full game; press number fail_at (counted over the game) is wrong, if reached.
    task automatic run_game(input int fail_at);
        int         presses;
        int         idle;
        logic [1:0] bad;
        presses = 0;
        start_game();
        for (int round = 1; round <= MAX_LEN; round++) begin
            check_playback();
            for (int i = 0; i < round; i++) begin
                check_outs("wait_step", 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
                idle = int'($urandom_range(0, 3));
                for (int w = 0; w < idle; w++) begin
                    check_outs("wait_idle", 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
                    step();
                end
                if (presses == fail_at) begin
                    bad = 2'(seq[i] + int'($urandom_range(1, 3)));
                    press(bad);
                    check_outs("over", 1'b0, 1'b1, 2'd0, 1'b1, 1'b0);
                    check("over_level", 32'(level), 32'(round));
                    step();
                    check_outs("over_hold", 1'b0, 1'b1, 2'd0, 1'b1, 1'b0);
                    return;
                end
                press(2'(seq[i]));
                presses++;
                for (int t = 0; t < TONE; t++) begin
                    check_outs("echo", 1'b0, 1'b1, 2'(seq[i]), 1'b0, 1'b0);
                    step();
                end
            end
            if (round == MAX_LEN) begin
                check_outs("win", 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
                check("win_level", 32'(level), 32'(MAX_LEN));
                for (int w = 0; w < GAP + 2; w++) begin
                    step();
                    check_outs("win_hold", 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
                end
                return;
            end
            for (int t = 0; t < GAP; t++) begin
                check_outs("pause", 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
                step();
            end
            check_outs("add_round", 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
            check("add_round_level", 32'(level), 32'(round));
            seq.push_back(int'(chan_now()));
            step();
        end
    endtask

    initial begin
        reset_dut();
        check_outs("reset", 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        check("reset_level", 32'(level), 32'd0);

        // ADD cycles of the table scenario fall 2 and 14 edges after reset.
        ch_a = 2'(lfsr_after(2) % NUM_CH);
        ch_b = 2'(lfsr_after(14) % NUM_CH);
        //           start pulse num        turn  act   num   over  win   chkl  lvl
        vecs[0]  = '{1'b1, 1'b0, 2'd0,      1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 2'd0};
        vecs[1]  = '{1'b0, 1'b0, 2'd0,      1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 2'd0};
        vecs[2]  = '{1'b0, 1'b0, 2'd0,      1'b1, 1'b1, ch_a, 1'b0, 1'b0, 1'b1, 2'd1};
        vecs[3]  = '{1'b0, 1'b1, ch_a,      1'b1, 1'b1, ch_a, 1'b0, 1'b0, 1'b1, 2'd1};
        vecs[4]  = '{1'b0, 1'b0, 2'd0,      1'b1, 1'b1, ch_a, 1'b0, 1'b0, 1'b1, 2'd1};
        vecs[5]  = '{1'b0, 1'b0, 2'd0,      1'b1, 1'b1, ch_a, 1'b0, 1'b0, 1'b1, 2'd1};
        vecs[6]  = '{1'b0, 1'b0, 2'd0,      1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 2'd1};
        vecs[7]  = '{1'b0, 1'b0, 2'd0,      1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 2'd1};
        vecs[8]  = '{1'b0, 1'b0, 2'd0,      1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 2'd1};
        vecs[9]  = '{1'b0, 1'b1, ch_a^2'd1, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 2'd1};
        vecs[10] = '{1'b0, 1'b0, 2'd0,      1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 2'd1};
        vecs[11] = '{1'b0, 1'b1, ch_a,      1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 2'd1};
        vecs[12] = '{1'b1, 1'b0, 2'd0,      1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0};
        vecs[13] = '{1'b0, 1'b0, 2'd0,      1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 2'd0};
        vecs[14] = '{1'b0, 1'b0, 2'd0,      1'b1, 1'b1, ch_b, 1'b0, 1'b0, 1'b1, 2'd1};
        vecs[15] = '{1'b0, 1'b0, 2'd0,      1'b1, 1'b1, ch_b, 1'b0, 1'b0, 1'b1, 2'd1};
        vecs[16] = '{1'b1, 1'b0, 2'd0,      1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0};
        vecs[17] = '{1'b0, 1'b0, 2'd0,      1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 2'd0};

        for (int r = 0; r < NVEC; r++) begin
            start = vecs[r].start;
            btn_pulse = vecs[r].pulse;
            btn_num = vecs[r].num;
            step();
            start = 1'b0;
            btn_pulse = 1'b0;
            check_outs($sformatf("vec%0d", r), vecs[r].e_turn, vecs[r].e_act, vecs[r].e_num,
                       vecs[r].e_over, vecs[r].e_win);
            if (vecs[r].chk_lvl)
                check($sformatf("vec%0d_level", r), 32'(level), 32'(vecs[r].e_lvl));
        end

        // Directed games: clean win, then immediate failure, then restart from OVER.
        reset_dut();
        run_game(-1);
        run_game(0);
        run_game(3);

        // Reset while a channel is sounding.
        start_game();
        step();
        reset = 1'b1;
        step();
        check_outs("reset_mid", 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        check("reset_mid_level", 32'(level), 32'd0);
        check("reset_mid_num", 32'(cur_num), 32'd0);
        reset = 1'b0;

        // Five-channel build: out-of-range press ignored in PLAY_ON, fatal in WAIT_IN.
        start5 = 1'b1;
        step();
        start5 = 1'b0;
        step();
        step();
        check("n5_play", 32'({turn5, act5, over5}), 32'(3'b110));
        btn5 = 3'd5;
        pulse5 = 1'b1;
        step();
        pulse5 = 1'b0;
        check("n5_ignored", 32'({turn5, act5, over5}), 32'(3'b110));
        for (int i = 0; i < 5; i++) step();
        check("n5_wait", 32'({turn5, act5, over5, win5}), 32'd0);
        pulse5 = 1'b1;
        step();
        pulse5 = 1'b0;
        check("n5_over", 32'({over5, act5, num5}), 32'({1'b1, 1'b1, 3'd0}));
        check("n5_level", 32'(level5), 32'd1);

`ifdef SIMON_TIMEOUT_EN
        start_game();
        check_playback();
        for (int i = 0; i < TOUT; i++) begin
            check("timeout_wait", 32'(game_over), 32'd0);
            step();
        end
        check_outs("timeout_over", 1'b0, 1'b1, 2'd0, 1'b1, 1'b0);
        start_game();
        check_playback();
        for (int i = 0; i < TOUT - 1; i++) step();
        press(2'(seq[0]));
        check_outs("late_press_echo", 1'b0, 1'b1, 2'(seq[0]), 1'b0, 1'b0);
`endif

        // Random games against the sequence/timing model.
        for (int g = 0; g < 12; g++) run_game(int'($urandom_range(0, 8)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
